// File: rtl/pulse_stretch.sv
// Stretches single-cycle tick strobes into WIDTH-cycle level pulses,
// then holds a GAP-cycle low gap; flags completions and ignored ticks.
module pulse_stretch #(
    parameter int WIDTH = 4,
    parameter int GAP   = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic retrig,
    output logic level,
    output logic busy,
    output logic done,
    output logic dropped
);
    localparam int MAXC = (WIDTH > GAP) ? WIDTH : GAP;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [CW-1:0] W_LOAD = CW'(WIDTH - 1);
    localparam logic [CW-1:0] G_LOAD = (GAP > 0) ? CW'(GAP - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          drop_nxt;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        drop_nxt  = 1'b0;
        case (state)
            S_IDLE: begin
                if (tick) begin
                    state_nxt = S_HIGH;
                    cnt_nxt   = W_LOAD;
                end
            end
            S_HIGH: begin
                // a non-retriggering tick is only reported; the pulse runs on
                drop_nxt = tick & ~retrig;
                if (tick && retrig) begin
                    cnt_nxt = W_LOAD;
                end else if (cnt == '0) begin
                    if (GAP > 0) begin
                        state_nxt = S_GAP;
                        cnt_nxt   = G_LOAD;
                    end else begin
                        state_nxt = S_IDLE;
                        cnt_nxt   = '0;
                    end
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            S_GAP: begin
                drop_nxt = tick;
                if (cnt == '0) begin
                    state_nxt = S_IDLE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            level   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            dropped <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            level   <= (state_nxt == S_HIGH);
            busy    <= (state_nxt != S_IDLE);
            done    <= (state == S_HIGH) && (state_nxt != S_HIGH);
            dropped <= drop_nxt;
        end
    end
endmodule

// File: tb/tb_pulse_stretch.sv
// Directed scenarios against two pulse_stretch configurations; expected
// per-cycle outputs are queued by the stimulus and checked by a monitor.
module tb_pulse_stretch;
    localparam int N = 24;

    logic clk = 1'b0;
    logic reset, tick, retrig;
    logic level_a, busy_a, done_a, dropped_a;
    logic level_b, busy_b, done_b, dropped_b;

    always #5 clk = ~clk;

    pulse_stretch #(.WIDTH(4), .GAP(2)) dut_a (
        .clk(clk), .reset(reset), .tick(tick), .retrig(retrig),
        .level(level_a), .busy(busy_a), .done(done_a), .dropped(dropped_a)
    );

    pulse_stretch #(.WIDTH(1), .GAP(0)) dut_b (
        .clk(clk), .reset(reset), .tick(tick), .retrig(retrig),
        .level(level_b), .busy(busy_b), .done(done_b), .dropped(dropped_b)
    );

    typedef struct {
        logic       sel;
        logic [3:0] exp;
        int         scn;
        int         cyc;
    } ent_t;

    ent_t q[$];
    int   total = 0;
    int   passed = 0;

    // expected vector order: {level, busy, done, dropped}
    always @(negedge clk) begin
        if (q.size() > 0) begin
            ent_t       e;
            logic [3:0] act;
            e   = q.pop_front();
            act = e.sel ? {level_b, busy_b, done_b, dropped_b}
                        : {level_a, busy_a, done_a, dropped_a};
            total++;
            if (act !== e.exp)
                $display("FAIL scn%0d cyc%0d {level,busy,done,dropped}: got %b want %b",
                         e.scn, e.cyc, act, e.exp);
            else
                passed++;
        end
    end

    task automatic preamble();
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            reset = 1'b0; tick = 1'b0; retrig = 1'b0;
        end
    endtask

    // rs bit set = reset asserted (low) in that cycle
    task automatic run(input int scn, input logic sel, input logic rt,
                       input logic [N-1:0] tk, input logic [N-1:0] rs,
                       input logic [N-1:0] lv, input logic [N-1:0] bz,
                       input logic [N-1:0] dn, input logic [N-1:0] dp);
        ent_t e;
        preamble();
        for (int c = 0; c < N; c++) begin
            @(posedge clk); #1;
            tick   = tk[c];
            reset  = ~rs[c];
            retrig = rt;
            e.sel = sel;
            e.exp = {lv[c], bz[c], dn[c], dp[c]};
            e.scn = scn;
            e.cyc = c;
            q.push_back(e);
        end
    endtask

    initial begin
        reset = 1'b0; tick = 1'b0; retrig = 1'b0;
        // 1: reset held with tick high, nothing may start
        run(1, 1'b0, 1'b0, 24'h000007, 24'h000007, 24'h0, 24'h0, 24'h0, 24'h0);
        // 2: single pulse
        run(2, 1'b0, 1'b0, 24'h000400, 24'h0, 24'h007800, 24'h01F800, 24'h008000, 24'h0);
        // 3: tick in GAP dropped, tick in first IDLE cycle accepted
        run(3, 1'b0, 1'b0, 24'h030400, 24'h0, 24'h3C7800, 24'hFDF800, 24'h408000, 24'h020000);
        // 4: retrigger mid-pulse
        run(4, 1'b0, 1'b1, 24'h002400, 24'h0, 24'h03F800, 24'h0FF800, 24'h040000, 24'h0);
        // 5: non-retrigger tick mid-pulse dropped
        run(5, 1'b0, 1'b0, 24'h001400, 24'h0, 24'h007800, 24'h01F800, 24'h008000, 24'h002000);
        // 6: reset mid-pulse (tick in reset cycle discarded), then a full pulse
        run(6, 1'b0, 1'b0, 24'h009400, 24'h001000, 24'h0F1800, 24'h3F1800, 24'h100000, 24'h0);
        // 7: WIDTH=1 GAP=0 back-to-back pulses
        run(7, 1'b1, 1'b0, 24'h001400, 24'h0, 24'h002800, 24'h002800, 24'h005000, 24'h0);
        // 8: retrigger on last HIGH cycle extends
        run(8, 1'b0, 1'b1, 24'h004400, 24'h0, 24'h07F800, 24'h1FF800, 24'h080000, 24'h0);
        // 9: tick on last HIGH cycle without retrigger is dropped
        run(9, 1'b0, 1'b0, 24'h004400, 24'h0, 24'h007800, 24'h01F800, 24'h008000, 24'h008000);
        repeat (3) @(posedge clk);
        if (q.size() != 0) begin
            total++;
            $display("FAIL drain: got %0d queued want 0", q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
